jump_state_ctrl: RTL and testbench
==================================

Name: jump_state_ctrl

Overview:
Top-level game controller for the jump game. It conditions the raw player key and sequences IDLE / READY / PRESS / JUMP / LAND / OVER. It produces the 3-bit state code consumed by the man-squeeze, jump-trajectory and display stages, plus the charge value (press duration) and the score. It handshakes with the landing judge to decide between continuing play and game over.

Parameters:
DEB_CYCLES, 16, consecutive clk cycles a synced key level must differ from the debounced level before the debounced level changes
CHARGE_W, 8, width of o_charge
CHARGE_MAX, 200, saturation value of charge
JUMP_TICKS, 32, i_tick pulses spent in JUMP
SCORE_W, 8, width of o_score

Ports:
clk_machine  in  1  system clock (25 MHz)
rst_machine  in  1  asynchronous reset, active-high
i_btn  in  1  raw key, asynchronous, 1 = pressed
i_tick  in  1  one-cycle game-step enable (frame rate)
i_land_valid  in  1  landing judge result valid
i_land_ok  in  1  landing judge result (1 = on platform); qualified by i_land_valid
o_state  out  3  state code
o_charge  out  CHARGE_W  accumulated press ticks
o_land_req  out  1  request to landing judge
o_score  out  SCORE_W  successful landings

Behaviour:
- Reset (async, any time, including mid-jump): o_state=0, o_charge=0, o_land_req=0, o_score=0, sync flops=0, debounced key=0, debounce counter=0.
- Key conditioning:
  - 2-flop synchronizer feeds a debounce counter.
  - The counter increments while synced != debounced, clears otherwise.
  - When the counter reaches DEB_CYCLES-1 while the mismatch persists, the debounced level toggles and the counter clears.
  - press_edge and release_edge are one-cycle pulses on debounced 0->1 and 1->0.
  - Total latency from raw change to o_state change: DEB_CYCLES+3 clk edges.
  - A key held through reset yields a press_edge after release of reset.
- State codes: 0 IDLE, 1 READY, 2 ARM, 3 PRESS, 4 JUMP, 5 LAND, 6 OVER. Code 7 is illegal and goes to IDLE on the next clock.
- IDLE: press_edge -> READY; o_score cleared to 0 on this transition.
- READY: press_edge -> ARM.
- ARM: exactly one cycle; o_charge cleared to 0; unconditionally -> PRESS.
- PRESS:
  - Each i_tick increments o_charge, saturating at CHARGE_MAX.
  - release_edge -> JUMP.
  - If release_edge and i_tick occur in the same cycle, the transition happens and the tick is not counted.
- JUMP:
  - o_charge held.
  - Tick counter clears on entry and counts i_tick.
  - On the JUMP_TICKS-th tick -> LAND.
- LAND:
  - o_land_req=1 (registered, asserted from the first LAND cycle until the cycle after i_land_valid is seen).
  - i_land_valid & i_land_ok -> READY, o_score+1 (saturating at all-ones), o_charge cleared.
  - i_land_valid & !i_land_ok -> OVER.
  - i_land_valid outside LAND is ignored.
- OVER: o_score and o_charge held; press_edge -> IDLE.
- Key edges are ignored in ARM, JUMP and LAND. A press held across LAND->READY does not start a charge; only a new press_edge does.
- i_tick is ignored outside PRESS and JUMP.
- All outputs are registered; o_state changes only on clk_machine rising edge.

Test Plan:
- Reset then idle, no key -> o_state=0, o_charge=0, o_score=0, o_land_req=0 indefinitely.
- Key glitch shorter than DEB_CYCLES (10 cycles high, DEB_CYCLES=16) -> no press_edge, o_state stays 0.
- Full successful round:
  - Stimulus: press/release to READY; press, then 50 i_tick pulses, then release; 32 ticks; i_land_valid=1 with i_land_ok=1.
  - Required: state sequence 0->1->2->3->4->5->1; o_charge=50 held through JUMP/LAND, then 0; o_score=1.
- Charge saturation: hold key for 300 ticks -> o_charge stops at 200; release with a coincident tick -> JUMP, o_charge=200.
- Failed landing: in LAND, i_land_valid=1 with i_land_ok=0 -> o_state=6 with score unchanged; next press_edge -> o_state=0; next press_edge -> READY with o_score=0.
- Assert rst_machine mid-JUMP (tick 10) -> all outputs 0 asynchronously; after release, the key must be cycled to leave IDLE.

Source files
------------

// File: rtl/jump_state_ctrl.sv
// rtl/jump_state_ctrl.sv - jump game controller: key debounce, game FSM, charge and score
//
// Ports:
//   clk_machine   in   system clock
//   rst_machine   in   asynchronous reset, active-high
//   i_btn         in   raw key, asynchronous, 1 = pressed
//   i_tick        in   one-cycle game-step enable
//   i_land_valid  in   landing judge result valid
//   i_land_ok     in   landing judge result, 1 = on platform
//   o_state       out  state code (0 IDLE .. 6 OVER)
//   o_charge      out  accumulated press ticks, saturating at CHARGE_MAX
//   o_land_req    out  request to landing judge while in LAND
//   o_score       out  successful landings, saturating at all-ones
module jump_state_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int CHARGE_W   = 8,
  parameter int CHARGE_MAX = 200,
  parameter int JUMP_TICKS = 32,
  parameter int SCORE_W    = 8
) (
  input  logic                clk_machine,
  input  logic                rst_machine,
  input  logic                i_btn,
  input  logic                i_tick,
  input  logic                i_land_valid,
  input  logic                i_land_ok,
  output logic [2:0]          o_state,
  output logic [CHARGE_W-1:0] o_charge,
  output logic                o_land_req,
  output logic [SCORE_W-1:0]  o_score
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int TICK_W = $clog2(JUMP_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_ARM   = 3'd2,
    S_PRESS = 3'd3,
    S_JUMP  = 3'd4,
    S_LAND  = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  // Key conditioning
  logic             sync_1, sync_2;
  logic             deb, deb_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             press_edge, release_edge;

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_1 <= i_btn;
      sync_2 <= sync_1;
      deb_q  <= deb;
      if (sync_2 != deb) begin
        // Mismatch must persist DEB_CYCLES consecutive cycles before the level flips.
        if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
          deb     <= ~deb;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // deb_q resets to 0, so a key held through reset still produces a press edge.
  assign press_edge   = deb & ~deb_q;
  assign release_edge = ~deb & deb_q;

  // Game FSM and its datapath registers
  state_t              state, state_n;
  logic [CHARGE_W-1:0] charge, charge_n;
  logic [SCORE_W-1:0]  score, score_n;
  logic [TICK_W-1:0]   tick_cnt, tick_n;
  logic                land_req, land_req_n;

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      state    <= S_IDLE;
      charge   <= '0;
      score    <= '0;
      tick_cnt <= '0;
      land_req <= 1'b0;
    end else begin
      state    <= state_n;
      charge   <= charge_n;
      score    <= score_n;
      tick_cnt <= tick_n;
      land_req <= land_req_n;
    end
  end

  always_comb begin
    state_n    = state;
    charge_n   = charge;
    score_n    = score;
    tick_n     = tick_cnt;
    land_req_n = land_req;
    case (state)
      S_IDLE: begin
        if (press_edge) begin
          state_n = S_READY;
          score_n = '0;
        end
      end
      S_READY: begin
        if (press_edge) begin
          state_n  = S_ARM;
          charge_n = '0;
        end
      end
      S_ARM: begin
        charge_n = '0;
        state_n  = S_PRESS;
      end
      S_PRESS: begin
        // Release wins over a coincident tick: the tick is dropped.
        if (release_edge) begin
          state_n = S_JUMP;
          tick_n  = '0;
        end else if (i_tick && (charge < CHARGE_W'(CHARGE_MAX))) begin
          charge_n = charge + CHARGE_W'(1);
        end
      end
      S_JUMP: begin
        if (i_tick) begin
          if (tick_cnt == TICK_W'(JUMP_TICKS - 1)) begin
            state_n    = S_LAND;
            land_req_n = 1'b1;
          end else begin
            tick_n = tick_cnt + TICK_W'(1);
          end
        end
      end
      S_LAND: begin
        land_req_n = 1'b1;
        if (i_land_valid) begin
          land_req_n = 1'b0;
          if (i_land_ok) begin
            state_n  = S_READY;
            charge_n = '0;
            if (score != '1) begin
              score_n = score + SCORE_W'(1);
            end
          end else begin
            state_n = S_OVER;
          end
        end
      end
      S_OVER: begin
        if (press_edge) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        // Code 7 is unreachable; recover to IDLE.
        state_n    = S_IDLE;
        land_req_n = 1'b0;
      end
    endcase
  end

  assign o_state    = state;
  assign o_charge   = charge;
  assign o_land_req = land_req;
  assign o_score    = score;

endmodule

// File: tb/tb_jump_state_ctrl.sv
// tb/tb_jump_state_ctrl.sv - self-checking bench for jump_state_ctrl
module tb_jump_state_ctrl;

  localparam int DEB  = 16;
  localparam int CMAX = 200;
  localparam int JT   = 32;

  logic       clk_machine = 1'b0;
  logic       rst_machine;
  logic       i_btn, i_tick, i_land_valid, i_land_ok;
  logic [2:0] o_state;
  logic [7:0] o_charge;
  logic       o_land_req;
  logic [7:0] o_score;

  int checks   = 0;
  int failures = 0;
  int m_charge = 0;
  int m_score  = 0;

  jump_state_ctrl #(
    .DEB_CYCLES(DEB),
    .CHARGE_W  (8),
    .CHARGE_MAX(CMAX),
    .JUMP_TICKS(JT),
    .SCORE_W   (8)
  ) dut (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .i_btn       (i_btn),
    .i_tick      (i_tick),
    .i_land_valid(i_land_valid),
    .i_land_ok   (i_land_ok),
    .o_state     (o_state),
    .o_charge    (o_charge),
    .o_land_req  (o_land_req),
    .o_score     (o_score)
  );

  always #20 clk_machine = ~clk_machine;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_machine);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int st, input int lreq);
    check({tag, ".state"}, {29'd0, o_state}, st);
    check({tag, ".charge"}, {24'd0, o_charge}, m_charge);
    check({tag, ".score"}, {24'd0, o_score}, m_score);
    check({tag, ".land_req"}, {31'd0, o_land_req}, lreq);
  endtask

  // Hold a key level long enough for it to propagate to o_state.
  task automatic key(input logic lvl);
    i_btn = lvl;
    step(DEB + 3);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      i_tick = 1'b1;
      step(1);
      i_tick = 1'b0;
      step(1);
    end
  endtask

  // Release so that a tick lands in the same cycle as the release edge.
  task automatic release_with_tick;
    i_btn = 1'b0;
    step(DEB + 2);
    i_tick = 1'b1;
    step(1);
    i_tick = 1'b0;
  endtask

  // One round starting in READY with the key released.
  task automatic play_round(input int n, input bit ok, input int wait_c);
    key(1'b1);
    m_charge = 0;
    check_out("arm", 2, 0);
    step(1);
    check_out("press_entry", 3, 0);
    ticks(n);
    m_charge = (n > CMAX) ? CMAX : n;
    check_out("press_charge", 3, 0);
    release_with_tick;
    check_out("jump_entry", 4, 0);
    i_land_valid = 1'b1;
    i_land_ok    = 1'b1;
    step(1);
    i_land_valid = 1'b0;
    check_out("jump_ignore_valid", 4, 0);
    ticks(JT - 1);
    check_out("jump_before_last", 4, 0);
    ticks(1);
    check_out("land_entry", 5, 1);
    step(wait_c);
    check_out("land_wait", 5, 1);
    i_land_valid = 1'b1;
    i_land_ok    = ok;
    step(1);
    i_land_valid = 1'b0;
    if (ok) begin
      m_score  = (m_score >= 255) ? 255 : m_score + 1;
      m_charge = 0;
      check_out("land_ok", 1, 0);
    end else begin
      check_out("land_fail", 6, 0);
    end
  endtask

  initial begin
    rst_machine  = 1'b1;
    i_btn        = 1'b0;
    i_tick       = 1'b0;
    i_land_valid = 1'b0;
    i_land_ok    = 1'b0;
    step(3);
    check_out("reset", 0, 0);
    rst_machine = 1'b0;
    step(50);
    check_out("idle_quiet", 0, 0);

    // Glitch shorter than the debounce window
    i_btn = 1'b1;
    step(10);
    i_btn = 1'b0;
    step(40);
    check_out("glitch", 0, 0);

    // Exact press latency IDLE -> READY
    i_btn = 1'b1;
    step(DEB + 2);
    check_out("latency_before", 0, 0);
    step(1);
    check_out("latency_at", 1, 0);
    key(1'b0);
    check_out("ready_release", 1, 0);

    // Directed full round, then saturation, then random rounds
    play_round(50, 1'b1, 3);
    play_round(300, 1'b1, 0);
    repeat (4) play_round($urandom_range(1, 120), 1'b1, $urandom_range(0, 5));

    // Failed landing, OVER -> IDLE -> READY with score cleared
    play_round($urandom_range(1, 120), 1'b0, 2);
    key(1'b1);
    check_out("over_to_idle", 0, 0);
    key(1'b0);
    key(1'b1);
    m_score = 0;
    check_out("idle_to_ready", 1, 0);
    key(1'b0);

    // Reset in the middle of a jump
    key(1'b1);
    step(1);
    ticks(20);
    release_with_tick;
    ticks(10);
    m_charge = 20;
    check_out("mid_jump", 4, 0);
    #5 rst_machine = 1'b1;
    #1;
    m_charge = 0;
    m_score  = 0;
    check_out("async_reset", 0, 0);
    step(2);
    rst_machine = 1'b0;
    step(40);
    check_out("after_reset_idle", 0, 0);
    key(1'b1);
    check_out("after_reset_press", 1, 0);
    key(1'b0);

    // Key held through reset yields a press after reset release
    i_btn       = 1'b1;
    rst_machine = 1'b1;
    step(2);
    check_out("held_in_reset", 0, 0);
    rst_machine = 1'b0;
    for (int i = 0; i < 40 && o_state !== 3'd1; i++) step(1);
    check_out("held_through_reset", 1, 0);
    i_btn = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
